// File: rtl/e203_subsys_mclkdiv_pkg.sv
// e203_subsys_mclkdiv_pkg: shared widths, defaults and reset ratio constants for the multi-channel clock divider
package e203_subsys_mclkdiv_pkg;
    localparam int MCLKDIV_NCH        = 2;
    localparam int MCLKDIV_DIVW       = 6;
    localparam int MCLKDIV_DIV_RST    = 0;
    localparam bit MCLKDIV_DIVBY1_RST = 1'b1;

    function automatic int mclkdiv_chw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/e203_subsys_mclkdiv_chan.sv
// e203_subsys_mclkdiv_chan: one divider channel with boundary-point config/enable application
module e203_subsys_mclkdiv_chan
    import e203_subsys_mclkdiv_pkg::*;
#(
    parameter int DIVW       = MCLKDIV_DIVW,
    parameter int DIV_RST    = MCLKDIV_DIV_RST,
    parameter bit DIVBY1_RST = MCLKDIV_DIVBY1_RST
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ch_en_i,
    input  logic            acc_i,
    input  logic            cfg_divby1_i,
    input  logic [DIVW-1:0] cfg_div_i,
    output logic            clkout_q_o,
    output logic            byp_o,
    output logic            run_o,
    output logic            pend_o,
    output logic            done_o
);
    logic [DIVW-1:0] cnt_q, cnt_d, div_q, div_d, pdiv_q, pdiv_d;
    logic            out_q, out_d, byp_q, byp_d, pbyp_q, pbyp_d;
    logic            pend_q, pend_d, run_q, run_d, done_q, done_d;
    logic            wrap, bp, apply;

    // Boundary point is the only place config and enable change; every change lands as a fresh period start
    always_comb begin
        wrap   = cnt_q == div_q;
        bp     = ~run_q | byp_q | (~out_q & wrap);
        apply  = bp & pend_q;
        pend_d = acc_i | (pend_q & ~bp);
        pdiv_d = acc_i ? cfg_div_i : pdiv_q;
        pbyp_d = acc_i ? cfg_divby1_i : pbyp_q;
        byp_d  = apply ? pbyp_q : byp_q;
        div_d  = apply ? pdiv_q : div_q;
        done_d = apply;
        run_d  = bp ? ch_en_i : run_q;
        out_d  = bp ? (ch_en_i & ~byp_d) : (wrap ? ~out_q : out_q);
        cnt_d  = (bp | wrap) ? '0 : cnt_q + DIVW'(1);
    end

    // Channel state register; reset drops any pending request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            out_q  <= 1'b0;
            div_q  <= DIVW'(DIV_RST);
            byp_q  <= DIVBY1_RST;
            pdiv_q <= '0;
            pbyp_q <= 1'b0;
            pend_q <= 1'b0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            div_q  <= div_d;
            byp_q  <= byp_d;
            pdiv_q <= pdiv_d;
            pbyp_q <= pbyp_d;
            pend_q <= pend_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign clkout_q_o = out_q;
    assign byp_o      = byp_q;
    assign run_o      = run_q;
    assign pend_o     = pend_q;
    assign done_o     = done_q;
endmodule

// File: rtl/e203_subsys_mclkdiv.sv
// e203_subsys_mclkdiv: NCH-channel runtime-reprogrammable glitch-free clock divider
module e203_subsys_mclkdiv
    import e203_subsys_mclkdiv_pkg::*;
#(
    parameter int NCH        = MCLKDIV_NCH,
    parameter int DIVW       = MCLKDIV_DIVW,
    parameter int DIV_RST    = MCLKDIV_DIV_RST,
    parameter bit DIVBY1_RST = MCLKDIV_DIVBY1_RST,
    localparam int CW        = mclkdiv_chw(NCH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            test_mode,
    input  logic [NCH-1:0]  ch_en,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [CW-1:0]   cfg_ch,
    input  logic            cfg_divby1,
    input  logic [DIVW-1:0] cfg_div,
    output logic [NCH-1:0]  cfg_done,
    output logic [NCH-1:0]  clkout,
    output logic [NCH-1:0]  ch_running
);
    logic [NCH-1:0] out_q, byp, run, pend, acc;

    // Ready reflects the addressed channel's pending slot; out-of-range targets are always accepted and dropped
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NCH; i++) if (cfg_ch == CW'(i)) cfg_ready = ~pend[i];
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        assign acc[g]    = cfg_valid & cfg_ready & (cfg_ch == CW'(g));
        assign clkout[g] = test_mode ? clk : (byp[g] ? (clk & run[g]) : out_q[g]);
        e203_subsys_mclkdiv_chan #(
            .DIVW(DIVW), .DIV_RST(DIV_RST), .DIVBY1_RST(DIVBY1_RST)
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .ch_en_i     (ch_en[g]),
            .acc_i       (acc[g]),
            .cfg_divby1_i(cfg_divby1),
            .cfg_div_i   (cfg_div),
            .clkout_q_o  (out_q[g]),
            .byp_o       (byp[g]),
            .run_o       (run[g]),
            .pend_o      (pend[g]),
            .done_o      (cfg_done[g])
        );
    end

    assign ch_running = run;
endmodule
